// File: rtl/center_pkg.sv
// ---------------------------------------------------------------------------
// center_pkg
// Shared types and helpers for the mean-removal (centering) stage.
//   state_t      : top-level FSM states.
//   acc_width()  : accumulator width that holds a full row sum without overflow.
//   recip_calc() : rounded fixed-point reciprocal of the sample count.
//   sat_signed() : clamps a signed value (up to 64 bits) to a signed width.
// ---------------------------------------------------------------------------
package center_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACC  = 3'd1,
        MEAN = 3'd2,
        SUB  = 3'd3,
        DONE = 3'd4
    } state_t;

    // A row sum of SAMPLES elements needs clog2(SAMPLES) extra bits.
    function automatic int acc_width(input int data_width, input int samples);
        return data_width + $clog2(samples);
    endfunction

    // Reciprocal of SAMPLES with RECIP_FRAC fractional bits, rounded to nearest.
    function automatic int recip_calc(input int recip_frac, input int samples);
        return ((1 << recip_frac) + samples / 2) / samples;
    endfunction

    // Clamp to [-2^(width-1), 2^(width-1)-1]; the caller keeps the low width bits.
    function automatic logic [63:0] sat_signed(input logic signed [63:0] value,
                                               input int                 width);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (value > max_v) begin
            return max_v;
        end else if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/center_mean_div.sv
// ---------------------------------------------------------------------------
// center_mean_div
// Row mean by constant-reciprocal multiply with round-half-up:
//   mean = (acc * RECIP + 2^(RECIP_FRAC-1)) >>> RECIP_FRAC, low DATA_WIDTH bits.
// One registered stage; the row tag travels with the result so the caller can
// write it back into its mean array.
// Ports:
//   clk, rstn        : clock, synchronous active-low reset
//   valid, row, acc  : one accumulator in, tagged with its row
//   mean_vld, mean_row, mean : registered mean out, one cycle later
// ---------------------------------------------------------------------------
module center_mean_div #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 36,
    parameter int RECIP_FRAC = 16,
    parameter int RECIP      = 6554,
    parameter int ROW_W      = 3
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         valid,
    input  logic [ROW_W-1:0]             row,
    input  logic signed [ACC_WIDTH-1:0]  acc,
    output logic                         mean_vld,
    output logic [ROW_W-1:0]             mean_row,
    output logic signed [DATA_WIDTH-1:0] mean
);

    // Product width: the sign-extended sum times a reciprocal of at most
    // 2^RECIP_FRAC, with headroom for the rounding add.
    localparam int PW = ACC_WIDTH + RECIP_FRAC + 2;
    localparam logic signed [PW-1:0] RECIP_C = PW'(RECIP);
    localparam logic signed [PW-1:0] HALF_C  = PW'(64'sd1 <<< (RECIP_FRAC - 1));

    logic signed [PW-1:0]         acc_ext;
    logic signed [PW-1:0]         rounded;
    logic signed [DATA_WIDTH-1:0] mean_next;
    logic                         mean_vld_reg;
    logic [ROW_W-1:0]             mean_row_reg;
    logic signed [DATA_WIDTH-1:0] mean_reg;

    always_comb begin
        acc_ext   = {{(PW - ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc};
        rounded   = acc_ext * RECIP_C + HALF_C;
        mean_next = DATA_WIDTH'(rounded >>> RECIP_FRAC);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            mean_vld_reg <= 1'b0;
            mean_row_reg <= '0;
            mean_reg     <= '0;
        end else begin
            mean_vld_reg <= valid;
            mean_row_reg <= row;
            mean_reg     <= mean_next;
        end
    end

    assign mean_vld = mean_vld_reg;
    assign mean_row = mean_row_reg;
    assign mean     = mean_reg;

endmodule

// File: rtl/center_unit.sv
// ---------------------------------------------------------------------------
// center_unit
// Mean-removal stage: latches a DIM x SAMPLES signed matrix, sums each row
// (ACC), converts sums to means one row per cycle (MEAN), then subtracts the
// row mean from every element (SUB). Result is held in DONE with cent_opvld.
// Ports:
//   clk, rstn   : clock, synchronous active-low reset
//   en          : start request, sampled in IDLE and DONE only
//   X_IN        : flat big-endian matrix, element (i,j) at
//                 [(i*SAMPLES+j)*DATA_WIDTH +: DATA_WIDTH]
//   X_CENT      : centered matrix, same layout
//   cent_opvld  : result valid
// Build option: define CENTER_SAT_EN to saturate the subtraction result;
// otherwise it wraps to DATA_WIDTH bits.
// ---------------------------------------------------------------------------
module center_unit
    import center_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DIM        = 5,
    parameter int SAMPLES    = 10,
    parameter int RECIP_FRAC = 16
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 en,
    input  logic [0:DATA_WIDTH*DIM*SAMPLES-1]    X_IN,
    output logic [0:DATA_WIDTH*DIM*SAMPLES-1]    X_CENT,
    output logic                                 cent_opvld
);

    localparam int N     = DIM * SAMPLES;
    localparam int AW    = acc_width(DATA_WIDTH, SAMPLES);
    localparam int RECIP = recip_calc(RECIP_FRAC, SAMPLES);
    localparam int ROW_W = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int COL_W = $clog2(SAMPLES);
    localparam int CNT_W = $clog2(N);

    state_t                         state_reg, state_next;
    logic [CNT_W-1:0]               cnt_reg;
    logic [ROW_W-1:0]               row_reg;
    logic [COL_W-1:0]               col_reg;
    logic                           opvld_reg;

    logic [DATA_WIDTH-1:0]          x_in_arr [N];
    logic [DATA_WIDTH-1:0]          x_reg    [N];
    logic [DATA_WIDTH-1:0]          cent_reg [N];
    logic signed [AW-1:0]           acc_reg  [DIM];
    logic signed [DATA_WIDTH-1:0]   mean_reg [DIM];

    logic                           div_vld;
    logic [ROW_W-1:0]               div_row;
    logic signed [DATA_WIDTH-1:0]   div_mean;

    logic                           last_elem;
    logic                           last_row;
    logic                           last_col;
    logic signed [DATA_WIDTH-1:0]   x_cur;
    logic signed [AW-1:0]           x_ext;
    logic signed [DATA_WIDTH-1:0]   mean_cur;
    logic signed [DATA_WIDTH:0]     diff;
    logic [DATA_WIDTH-1:0]          sub_result;

    // Flat bus <-> element arrays.
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign x_in_arr[gi] = X_IN[gi*DATA_WIDTH +: DATA_WIDTH];
        assign X_CENT[gi*DATA_WIDTH +: DATA_WIDTH] = cent_reg[gi];
    end

    assign last_elem = (cnt_reg == CNT_W'(N - 1));
    assign last_row  = (row_reg == ROW_W'(DIM - 1));
    assign last_col  = (col_reg == COL_W'(SAMPLES - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (en)        state_next = ACC;
            ACC:     if (last_elem) state_next = MEAN;
            MEAN:    if (last_row)  state_next = SUB;
            SUB:     if (last_elem) state_next = DONE;
            DONE:    if (!en)       state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Subtract path. The last mean leaves the divider on the first SUB edge,
    // so forward it when SUB asks for that row before it lands in mean_reg.
    always_comb begin
        x_cur    = x_reg[cnt_reg];
        x_ext    = {{(AW - DATA_WIDTH){x_cur[DATA_WIDTH-1]}}, x_cur};
        mean_cur = (div_vld && (div_row == row_reg)) ? div_mean : mean_reg[row_reg];
        diff     = {x_cur[DATA_WIDTH-1], x_cur} - {mean_cur[DATA_WIDTH-1], mean_cur};
`ifdef CENTER_SAT_EN
        sub_result = DATA_WIDTH'(sat_signed(64'(diff), DATA_WIDTH));
`else
        sub_result = DATA_WIDTH'(diff);
`endif
    end

    center_mean_div #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (AW),
        .RECIP_FRAC (RECIP_FRAC),
        .RECIP      (RECIP),
        .ROW_W      (ROW_W)
    ) u_mean_div (
        .clk      (clk),
        .rstn     (rstn),
        .valid    (state_reg == MEAN),
        .row      (row_reg),
        .acc      (acc_reg[row_reg]),
        .mean_vld (div_vld),
        .mean_row (div_row),
        .mean     (div_mean)
    );

    // Input copy: captured only on the start cycle, so later X_IN changes
    // cannot disturb a run in progress.
    always_ff @(posedge clk) begin
        if ((state_reg == IDLE) && en) begin
            x_reg <= x_in_arr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            row_reg   <= '0;
            col_reg   <= '0;
            opvld_reg <= 1'b0;
            for (int i = 0; i < N; i++)   cent_reg[i] <= '0;
            for (int i = 0; i < DIM; i++) acc_reg[i]  <= '0;
            for (int i = 0; i < DIM; i++) mean_reg[i] <= '0;
        end else begin
            state_reg <= state_next;
            // Valid follows DONE by one edge and lingers one edge after leaving it.
            opvld_reg <= (state_reg == DONE);

            // Counters restart on every state change; row/col track cnt so the
            // row index never needs a divide.
            if (state_next != state_reg) begin
                cnt_reg <= '0;
                row_reg <= '0;
                col_reg <= '0;
            end else if ((state_reg == ACC) || (state_reg == SUB)) begin
                cnt_reg <= cnt_reg + 1'b1;
                if (last_col) begin
                    col_reg <= '0;
                    row_reg <= row_reg + 1'b1;
                end else begin
                    col_reg <= col_reg + 1'b1;
                end
            end else if (state_reg == MEAN) begin
                row_reg <= row_reg + 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (en) begin
                        for (int i = 0; i < N; i++)   cent_reg[i] <= '0;
                        for (int i = 0; i < DIM; i++) acc_reg[i]  <= '0;
                    end
                end
                ACC:     acc_reg[row_reg]  <= acc_reg[row_reg] + x_ext;
                SUB:     cent_reg[cnt_reg] <= sub_result;
                default: ;
            endcase

            if (div_vld) begin
                mean_reg[div_row] <= div_mean;
            end
        end
    end

    assign cent_opvld = opvld_reg;

endmodule

// File: tb/tb_center_unit.sv
module tb_center_unit;

    localparam int DW  = 32;
    localparam int DIM = 5;
    localparam int S   = 10;
    localparam int F   = 16;
    localparam int N   = DIM * S;
    localparam int NB  = DW * N;
    localparam int LAT = 1 + 2 * N + DIM;
    localparam longint RECIP = ((longint'(1) << F) + S / 2) / S;

    logic          clk = 1'b0;
    logic          rstn;
    logic          en;
    logic [0:NB-1] x_in;
    logic [0:NB-1] x_cent;
    logic          cent_opvld;

    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    int            start_cyc = 0;
    logic [0:NB-1] sb_q [$];
    logic [0:NB-1] last_exp;
    logic [0:NB-1] zero_v;
    logic [0:NB-1] mat_a, mat_b, mat_c, mat_d;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    center_unit #(
        .DATA_WIDTH (DW),
        .DIM        (DIM),
        .SAMPLES    (S),
        .RECIP_FRAC (F)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .X_IN       (x_in),
        .X_CENT     (x_cent),
        .cent_opvld (cent_opvld)
    );

    // Reference: row mean via rounded reciprocal, then subtract with wrap or clamp.
    function automatic logic [0:NB-1] model(input logic [0:NB-1] x);
        logic [0:NB-1]      r;
        logic signed [31:0] e;
        logic signed [31:0] m32;
        longint             sum, mean_l, d;
        r = '0;
        for (int i = 0; i < DIM; i++) begin
            sum = 0;
            for (int j = 0; j < S; j++) begin
                e = x[(i*S+j)*DW +: DW];
                sum += longint'(e);
            end
            mean_l = (sum * RECIP + (longint'(1) << (F - 1))) >>> F;
            m32 = mean_l[31:0];
            for (int j = 0; j < S; j++) begin
                e = x[(i*S+j)*DW +: DW];
                d = longint'(e) - longint'(m32);
`ifdef CENTER_SAT_EN
                if (d > 64'sd2147483647)       d = 64'sd2147483647;
                else if (d < -64'sd2147483648) d = -64'sd2147483648;
`endif
                r[(i*S+j)*DW +: DW] = d[31:0];
            end
        end
        return r;
    endfunction

    function automatic logic [0:NB-1] rand_mat();
        logic [0:NB-1] r;
        for (int k = 0; k < N; k++) r[k*DW +: DW] = $urandom();
        return r;
    endfunction

    // Drive a start request; the next rising edge is edge 0 of the run.
    task automatic start_run(input logic [0:NB-1] m);
        @(negedge clk);
        x_in = m;
        en = 1'b1;
        start_cyc = cyc + 1;
        sb_q.push_back(model(m));
    endtask

    task automatic wait_and_check(input string tag);
        int            lat;
        logic [0:NB-1] exp_v;
        logic [DW-1:0] o, e;
        lat = -1;
        for (int k = 0; k < LAT + 50 && lat < 0; k++) begin
            @(negedge clk);
            if (cent_opvld === 1'b1) lat = cyc - start_cyc;
        end
        checks++;
        assert (lat === LAT) else begin
            errors++;
            $error("FAIL %s_latency observed=%0d expected=%0d", tag, lat, LAT);
        end
        exp_v = '0;
        if (sb_q.size() > 0) begin
            exp_v = sb_q.pop_front();
        end else begin
            errors++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
        end
        last_exp = exp_v;
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < S; j++) begin
                o = x_cent[(i*S+j)*DW +: DW];
                e = exp_v[(i*S+j)*DW +: DW];
                checks++;
                assert (o === e) else begin
                    errors++;
                    $error("FAIL %s_elem(%0d,%0d) observed=%h expected=%h", tag, i, j, o, e);
                end
            end
        end
        $display("run %s: valid after %0d edges, %0d elements compared", tag, lat, N);
    endtask

    initial begin
        zero_v = '0;
        rstn = 1'b0;
        en   = 1'b0;
        x_in = '0;

        // Directed matrix: constant row, ramp, negative constant, random, overflow row.
        mat_a = rand_mat();
        for (int j = 0; j < S; j++) begin
            mat_a[(0*S+j)*DW +: DW] = 32'd7;
            mat_a[(1*S+j)*DW +: DW] = 32'(j);
            mat_a[(2*S+j)*DW +: DW] = -32'sd3;
            mat_a[(4*S+j)*DW +: DW] = (j == S - 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
        end
        mat_b = rand_mat();
        mat_c = rand_mat();
        mat_d = rand_mat();
        for (int j = 0; j < S; j++) mat_d[(3*S+j)*DW +: DW] = 32'(S - 1 - j);

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        assert (cent_opvld === 1'b0) else begin
            errors++;
            $error("FAIL reset_opvld observed=%b expected=0", cent_opvld);
        end
        checks++;
        assert (x_cent === zero_v) else begin
            errors++;
            $error("FAIL reset_xcent observed=%h expected=0", x_cent[0:DW-1]);
        end
        rstn = 1'b1;

        // Run A; X_IN scrambled one cycle after start must not matter.
        start_run(mat_a);
        @(negedge clk);
        x_in = rand_mat();
        wait_and_check("runA");

        // en held high through DONE: valid stays, result unchanged, no restart.
        repeat (LAT + 20) @(negedge clk);
        checks++;
        assert (cent_opvld === 1'b1) else begin
            errors++;
            $error("FAIL hold_opvld observed=%b expected=1", cent_opvld);
        end
        checks++;
        assert (x_cent === last_exp) else begin
            errors++;
            $error("FAIL hold_xcent observed=%h expected=%h", x_cent[0:DW-1], last_exp[0:DW-1]);
        end
        $display("hold: en high for %0d cycles in DONE", LAT + 20);

        // Back-to-back: en low for one cycle, new data, start again.
        @(negedge clk);
        en = 1'b0;
        start_run(mat_b);
        wait_and_check("runB");

        // Reset during SUB aborts the run and clears outputs.
        @(negedge clk);
        en = 1'b0;
        start_run(mat_c);
        while (cyc - start_cyc < 70) @(negedge clk);
        rstn = 1'b0;
        en   = 1'b0;
        @(negedge clk);
        sb_q.delete();
        checks++;
        assert (cent_opvld === 1'b0) else begin
            errors++;
            $error("FAIL abort_opvld observed=%b expected=0", cent_opvld);
        end
        checks++;
        assert (x_cent === zero_v) else begin
            errors++;
            $error("FAIL abort_xcent observed=%h expected=0", x_cent[0:DW-1]);
        end
        $display("abort: reset applied %0d edges into run", 70);
        rstn = 1'b1;

        // Fresh run after the abort.
        start_run(mat_d);
        wait_and_check("runD");

        @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
